iobus_timer: RTL

//  Memory-mapped countdown timer that responds on the OTTER IOBUS (MCU is the initiator).

---
 rtl/iobus_timer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/iobus_timer.sv
// iobus_timer: memory-mapped countdown timer on the OTTER IOBUS.
// CTRL/LOAD/COUNT/STATUS at BASE_ADDR+0x0..0xC, level interrupt on expiry.
module iobus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          PRESCALE  = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        SEL,
    output logic        INTR
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [2:0]    r_ctrl;   // [0]EN [1]AR [2]IE
    logic [31:0]   r_load;
    logic [31:0]   r_count;
    logic          r_exp;
    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;

    logic          w_sel;
    logic          w_we;
    logic [1:0]    w_off;
    logic          w_wr_ctrl, w_wr_load, w_wr_count, w_wr_stat;
    logic          w_en_on, w_en_off;
    logic          w_tick;
    logic          w_expire;
    logic [1:0]    w_state_nxt;
    logic [31:0]   w_count_nxt;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Byte-lane bits are don't-care: word access only.
    assign w_unused   = ^IOBUS_ADDR[1:0];

    assign w_sel      = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign w_we       = IOBUS_WR & w_sel;
    assign w_off      = IOBUS_ADDR[3:2];
    assign w_wr_ctrl  = w_we && (w_off == 2'd0);
    assign w_wr_load  = w_we && (w_off == 2'd1);
    assign w_wr_count = w_we && (w_off == 2'd2);
    assign w_wr_stat  = w_we && (w_off == 2'd3);

    // EN only rises from IDLE (EN is 0 there), so the 0->1 test is against the live bit.
    assign w_en_on    = w_wr_ctrl &&  IOBUS_OUT[0] && !r_ctrl[0];
    assign w_en_off   = w_wr_ctrl && !IOBUS_OUT[0];

    assign w_tick     = (r_state == ST_RUN) && (r_presc == PW'(PRESCALE - 1));
    // Expiry is suppressed by a same-cycle COUNT write or by leaving RUN.
    // LOAD=0 lands here like LOAD=1 since COUNT<=1 is the expiry test.
    assign w_expire   = w_tick && !w_en_off && !w_wr_count && (r_count <= 32'd1);

    // Next state and next count; a COUNT write overrides any decrement or reload.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_en_on) begin
                    w_state_nxt = ST_RUN;
                    w_count_nxt = r_load;
                end
            end
            ST_RUN: begin
                if (w_en_off) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick && !w_wr_count) begin
                    if (r_count > 32'd1) begin
                        w_count_nxt = r_count - 32'd1;
                    end else if (r_ctrl[1]) begin
                        w_count_nxt = r_load;   // old LOAD even if LOAD is being written
                    end else begin
                        w_count_nxt = 32'd0;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (w_en_off) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wr_count && (IOBUS_OUT != 32'd0)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_wr_count) begin
            w_count_nxt = IOBUS_OUT;
        end
    end

    // FSM state and count register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Prescaler runs only while staying in RUN; anything else parks it at 0.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end else begin
            r_presc <= '0;
        end
    end

    // Software-written CTRL and LOAD; reserved CTRL bits are dropped.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ctrl <= 3'd0;
            r_load <= 32'd0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= IOBUS_OUT[2:0];
            if (w_wr_load) r_load <= IOBUS_OUT;
        end
    end

    // Sticky expiry flag; a set in the same cycle beats a W1C clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_exp <= 1'b0;
        end else if (w_expire) begin
            r_exp <= 1'b1;
        end else if (w_wr_stat && IOBUS_OUT[0]) begin
            r_exp <= 1'b0;
        end
    end

    // Combinational read mux, no read side effects.
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            2'd0:    w_rdata = {29'd0, r_ctrl};
            2'd1:    w_rdata = r_load;
            2'd2:    w_rdata = r_count;
            default: w_rdata = {31'd0, r_exp};
        endcase
    end

    assign IOBUS_IN = w_sel ? w_rdata : 32'd0;
    assign SEL      = w_sel;
    assign INTR     = r_exp & r_ctrl[2];

endmodule
